// File: rtl/mac_accum_pkg.sv
// Shared fixed-point format constants for the ELU layer datapath.
// Data words are signed Q8.10; the accumulator is 32 bits wide.
package mac_accum_pkg;

  localparam int DATA_LEN = 18;
  localparam int DATA_INT = 8;
  localparam int DATA_DEC = 10;
  localparam int ACC_LEN  = 32;

endpackage

// File: rtl/fx_saturate.sv
// Combinational clamp of a wide signed value into a narrower signed word.
// sat is raised whenever the value did not fit and the clamp was applied.
module fx_saturate
  import mac_accum_pkg::*;
#(
  parameter int in_width  = ACC_LEN,
  parameter int out_width = DATA_LEN
) (
  input  logic signed [in_width-1:0]  d,
  output logic signed [out_width-1:0] q,
  output logic                        sat
);

  // The value fits only when every bit above the output sign bit matches the input sign.
  always_comb begin
    sat = 1'b0;
    q   = d[out_width-1:0];
    if (d[in_width-1:out_width-1] != {(in_width-out_width+1){d[in_width-1]}}) begin
      sat = 1'b1;
      q   = d[in_width-1] ? {1'b1, {(out_width-1){1'b0}}}
                          : {1'b0, {(out_width-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accum.sv
// Streaming multiply-accumulate stage feeding elu_table: multiply, round and
// accumulate a vector, add the neuron bias, then saturate to the data format.
module mac_accum
  import mac_accum_pkg::*;
#(
  parameter int dlen      = DATA_LEN,
  parameter int frac      = DATA_DEC,
  parameter int acc_width = ACC_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic signed [dlen-1:0] a,
  input  logic signed [dlen-1:0] b,
  input  logic signed [dlen-1:0] bias,
  output logic                   out_valid,
  output logic signed [dlen-1:0] out_q,
  output logic                   out_sat
);

  localparam int PW = 2 * dlen;
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (frac - 1);

  logic signed [PW-1:0]        p1;
  logic                        v1;
  logic                        l1;
  logic signed [dlen-1:0]      b1;

  logic signed [acc_width-1:0] acc;
  logic                        first;
  logic                        v2;
  logic signed [acc_width-1:0] sum2;

  logic signed [PW-1:0]        p_shift;
  logic signed [acc_width-1:0] s;
  logic signed [acc_width-1:0] acc_new;
  logic signed [acc_width-1:0] sum_new;

  logic signed [dlen-1:0]      sat_q;
  logic                        sat_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
      b1 <= '0;
    end else begin
      p1 <= a * b;
      v1 <= in_valid;
      l1 <= in_valid & in_last;
      if (in_valid & in_last) begin
        b1 <= bias;
      end
    end
  end

  // Round half up, then drop the extra fraction bits of the product.
  always_comb begin
    p_shift = (p1 + HALF) >>> frac;
    s       = acc_width'(p_shift);
    acc_new = (first ? '0 : acc) + s;
    sum_new = acc_new + acc_width'(b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      first <= 1'b1;
      v2    <= 1'b0;
      sum2  <= '0;
    end else begin
      v2 <= v1 & l1;
      if (v1) begin
        acc   <= acc_new;
        first <= l1;
        sum2  <= sum_new;
      end
    end
  end

  fx_saturate #(
    .in_width (acc_width),
    .out_width(dlen)
  ) u_sat (
    .d  (sum2),
    .q  (sat_q),
    .sat(sat_flag)
  );

  // Result registers hold between pulses so elu_table sees a stable input.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_q   <= sat_q;
        out_sat <= sat_flag;
      end
    end
  end

endmodule
